// File: rtl/famicom_bus_master.sv
// famicom_bus_master: 2A03-style CPU bus sequencer with a one-entry request buffer,
// registered M2/ROMSEL/data-enable generation and a two-flop IRQ synchronizer.
module famicom_bus_master #(
    parameter int CYCLE_LEN = 12,
    parameter int M2_RISE   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic        rsp_rw,
    output logic [7:0]  rsp_rdata,
    output logic        m2,
    output logic        romsel,
    output logic        cpu_rw_out,
    output logic [14:0] cpu_addr_out,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_oe,
    input  logic [7:0]  cpu_data_in,
    input  logic        irq,
    output logic        irq_pending
);
    localparam logic [3:0] LAST = 4'(CYCLE_LEN - 1);
    localparam logic [3:0] RISE = 4'(M2_RISE);

    logic [3:0]  phase, nxt_phase;
    logic        wrap, nxt_m2, hs, n_rw;
    logic        act_bus, act_a15, irq_s1, irq_s2;
    logic        buf_valid, buf_rw;
    logic [15:0] buf_addr, n_addr;
    logic [7:0]  buf_wdata, n_wdata;

    // Bus-visible cycle state only changes at the wrap into phase 0.
    always_comb begin
        wrap      = phase == LAST;
        nxt_phase = wrap ? 4'd0 : phase + 4'd1;
        nxt_m2    = nxt_phase >= RISE;
        hs        = req_valid & req_ready;
        n_rw      = wrap ? (~buf_valid | buf_rw) : cpu_rw_out;
        n_addr    = wrap ? (buf_valid ? buf_addr : 16'h0000) : {act_a15, cpu_addr_out};
        n_wdata   = wrap ? ((buf_valid & ~buf_rw) ? buf_wdata : 8'h00) : cpu_data_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase        <= 4'd0;
            m2           <= 1'b0;
            romsel       <= 1'b1;
            cpu_rw_out   <= 1'b1;
            cpu_addr_out <= 15'h0000;
            cpu_data_out <= 8'h00;
            cpu_data_oe  <= 1'b0;
            act_bus      <= 1'b0;
            act_a15      <= 1'b0;
            buf_valid    <= 1'b0;
            buf_rw       <= 1'b1;
            buf_addr     <= 16'h0000;
            buf_wdata    <= 8'h00;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rw       <= 1'b1;
            rsp_rdata    <= 8'h00;
            irq_s1       <= 1'b1;
            irq_s2       <= 1'b1;
            irq_pending  <= 1'b0;
        end else begin
            phase        <= nxt_phase;
            m2           <= nxt_m2;
            cpu_rw_out   <= n_rw;
            act_a15      <= n_addr[15];
            cpu_addr_out <= n_addr[14:0];
            cpu_data_out <= n_wdata;
            cpu_data_oe  <= ~n_rw & nxt_m2;
            romsel       <= ~(n_addr[15] & nxt_m2);
            if (wrap) act_bus <= buf_valid;
            rsp_valid    <= wrap & act_bus;
            if (wrap & act_bus) begin
                rsp_rw    <= cpu_rw_out;
                rsp_rdata <= cpu_rw_out ? cpu_data_in : 8'h00;
            end
            // A request is only accepted into an already-empty buffer, so it never bypasses.
            if (hs) begin
                buf_valid <= 1'b1;
                buf_rw    <= req_rw;
                buf_addr  <= req_addr;
                buf_wdata <= req_wdata;
            end else if (wrap) begin
                buf_valid <= 1'b0;
            end
            req_ready    <= ~(hs | (buf_valid & ~wrap));
            irq_s1       <= irq;
            irq_s2       <= irq_s1;
            if (wrap) irq_pending <= ~irq_s2;
        end
    end
endmodule

// File: doc/famicom_bus_master.md
FAMICOM_BUS_MASTER -- requirements
Module: famicom_bus_master

Interface
REQ-001 SHALL have parameter CYCLE_LEN, default 12, meaning clk periods per CPU bus cycle (legal range 6..15).
REQ-002 SHALL have parameter M2_RISE, default 5, meaning phase index at which m2 rises (legal range 2..CYCLE_LEN-3).
REQ-003 SHALL have ports:
  clk  input  1  master clock; all state on rising edge
  rst_n  input  1  asynchronous, active-low reset
  req_valid  input  1  bus-cycle request present
  req_ready  output  1  request buffer can accept
  req_rw  input  1  1=read, 0=write
  req_addr  input  16  CPU address
  req_wdata  input  8  write data
  rsp_valid  output  1  one-clk pulse, cycle completed
  rsp_rw  output  1  rw of completed cycle
  rsp_rdata  output  8  captured read data (0x00 for writes)
  m2  output  1  CPU M2 phase clock
  romsel  output  1  active-low, = ~(A15 & m2)
  cpu_rw_out  output  1  bus R/W
  cpu_addr_out  output  15  bus A14..A0
  cpu_data_out  output  8  write data to bus
  cpu_data_oe  output  1  drive enable for cpu_data_out
  cpu_data_in  input  8  bus data from cartridge
  irq  input  1  cartridge IRQ, active-low, asynchronous
  irq_pending  output  1  synchronized IRQ level, sampled at m2 fall

Function
REQ-004 SHALL run a phase counter 0..CYCLE_LEN-1, incrementing every clk and wrapping to 0; m2 toggles continuously, including with no requests.
REQ-005 SHALL hold m2=0 for phases 0..M2_RISE-1 and m2=1 for phases M2_RISE..CYCLE_LEN-1, registered (no glitches).
REQ-006 SHALL provide a one-entry request buffer; req_ready = buffer empty; handshake = req_valid & req_ready on a rising clk edge.
REQ-007 SHALL, on the transition into phase 0, load the buffered request into the active cycle (BUS state) and empty the buffer; if the buffer is empty, run an IDLE cycle: read of address 0x0000, rw=1, no rsp_valid.
REQ-008 SHALL permit the buffer to be filled in the same clk it is consumed at phase 0 only if it was already empty before that edge (no bypass; minimum request-to-bus latency 1 clk, maximum CYCLE_LEN clk).
REQ-009 SHALL hold cpu_addr_out=addr[14:0] and cpu_rw_out for all phases of a cycle; romsel=0 only while m2=1 and addr[15]=1.
REQ-010 SHALL, for writes, assert cpu_data_oe and drive wdata from phase M2_RISE through CYCLE_LEN-1; cpu_data_oe=0 at all other times and for all reads.
REQ-011 SHALL capture cpu_data_in into rsp_rdata on the clk edge ending phase CYCLE_LEN-1 (last clk with m2=1) for reads.
REQ-012 SHALL pulse rsp_valid for exactly one clk, in phase 0 of the following cycle, for each BUS cycle; rsp_rw and rsp_rdata stable until next rsp_valid.
REQ-013 SHALL synchronize irq through two flops; irq_pending updates to the inverted synchronized value only on the clk where m2 falls (phase CYCLE_LEN-1 -> 0).
REQ-014 SHALL never change address, rw or data mid-cycle, even when a new request is accepted during the cycle.

Reset
REQ-015 SHALL, while rst_n=0, force: phase=0, m2=0, romsel=1, cpu_rw_out=1, cpu_addr_out=0, cpu_data_oe=0, cpu_data_out=0, buffer empty, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_rw=1, irq_pending=0, sync flops=1.
REQ-016 SHALL assert req_ready on the first clk after rst_n deasserts; first post-reset cycle begins at phase 0 as IDLE unless a request was accepted in that clk.
REQ-017 SHALL abandon an in-flight cycle on reset assertion without issuing rsp_valid; a buffered request is discarded.

Verification
REQ-018 Idle: no requests for 48 clk after reset -> m2 period 12 clk (5 low/7 high), romsel=1, rw=1, addr=0, rsp_valid never asserted.
REQ-019 Read: request rw=1 addr=0x8123, cartridge model drives 0x5A -> romsel=0 exactly during 7 m2-high clk, addr_out=0x0123, rsp_valid one pulse with rsp_rdata=0x5A, rsp_rw=1.
REQ-020 Write: rw=0 addr=0x6000 wdata=0xA5 -> romsel=1 throughout, cpu_data_oe=1 only during m2 high with data 0xA5, rsp_valid pulse with rsp_rdata=0x00.
REQ-021 Back-to-back: 4 requests with req_valid held high -> req_ready deasserts after first accept, 4 consecutive BUS cycles with no intervening IDLE, 4 rsp_valid pulses 12 clk apart in order.
REQ-022 IRQ: irq driven low mid-cycle -> irq_pending=1 at first m2 fall at least 2 clk later; irq released -> irq_pending=0 at subsequent m2 fall.
REQ-023 Reset mid-write at phase 8 -> all outputs to REQ-015 values immediately, no rsp_valid, bus resumes cleanly with IDLE cycle after release.
